johnson_phase_tracker: RTL
==========================

JOHNSON_PHASE_TRACKER -- requirements
Module: johnson_phase_tracker

Interface
REQ-001 Parameter: LOCK_COUNT, 3, consecutive correct transitions required to enter LOCKED (legal range 1..15).
REQ-002 Parameter: ERR_W, 8, width of the error counter.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 jc_in  input  4  4-bit Johnson code from the upstream counter.
REQ-006 jc_valid  input  1  jc_in is sampled on this edge.
REQ-007 phase  output  3  decoded phase index of the last legal sample, registered.
REQ-008 phase_onehot  output  8  one-hot form of phase (bit n set for phase n).
REQ-009 locked  output  1  tracker is in the LOCKED state.
REQ-010 err_pulse  output  1  single-cycle error strobe.
REQ-011 wrap_pulse  output  1  single-cycle strobe on an accepted 7->0 transition while LOCKED.
REQ-012 err_count  output  ERR_W  saturating count of err_pulse events.

Function
REQ-013 Legal decode SHALL be fixed: 0000->0, 1000->1, 1100->2, 1110->3, 1111->4, 0111->5, 0011->6, 0001->7. The other 8 codes are illegal.
REQ-014 The expected successor of phase p SHALL be (p+1) mod 8.
REQ-015 All outputs SHALL be registered and reflect a sample exactly 1 cycle after the jc_valid edge. Latency is 1.
REQ-016 When jc_valid=0, state, phase, match counter and stored previous sample SHALL hold. err_pulse and wrap_pulse SHALL be 0.
REQ-017 FSM states: SEARCH and LOCKED.
REQ-018 SEARCH behaviour on a legal sample:
  - if a previous legal sample is stored and this sample is its successor: match_cnt += 1
  - otherwise: match_cnt is set to 0
  - in both cases the sample is stored as the previous sample.
REQ-019 SEARCH -> LOCKED SHALL occur on the sample that brings match_cnt to LOCK_COUNT. locked rises 1 cycle later.
REQ-020 LOCKED behaviour on a legal successor sample: stay LOCKED and update phase.
REQ-021 LOCKED behaviour on any other sample (legal non-successor, a repeat of the current code, or illegal): go to SEARCH, clear match_cnt, assert err_pulse.
REQ-022 An illegal sample in any state SHALL:
  - assert err_pulse
  - clear match_cnt
  - invalidate the stored previous sample
  - leave phase unchanged.
REQ-023 A legal sample in SEARCH SHALL NOT assert err_pulse, even if it is a non-successor.
REQ-024 phase SHALL update to the decoded value of every legal valid sample, in either state.
REQ-025 wrap_pulse SHALL assert only when LOCKED accepts a 0001 -> 0000 transition.
REQ-026 err_count SHALL increment on each err_pulse and saturate at all-ones. err_pulse still asserts while saturated.
REQ-027 The first legal sample after an error SHALL count as a new start (match_cnt=0). Relocking requires LOCK_COUNT further correct transitions.

Reset
REQ-028 While reset=1 on a clk edge, the block SHALL reset to:
  - state=SEARCH, match_cnt=0, previous sample invalid
  - phase=0, phase_onehot=8'h01
  - locked=0, err_pulse=0, wrap_pulse=0, err_count=0.
REQ-029 reset SHALL take priority over jc_valid, including reset asserted mid-lock. The first sample after reset is treated as a new start.

Configuration
REQ-030 Macro JOHNSON_PHASE_ONEHOT_EN controls the one-hot decoder.
  - Defined: phase_onehot is driven per REQ-008, registered and aligned with phase.
  - Undefined: phase_onehot is tied to 8'h00 and no one-hot registers are built. All other behaviour is identical.

Verification
REQ-031 Reset sequencing: reset for 2 cycles, then 0000,1000,1100,1110 valid on consecutive cycles (LOCK_COUNT=3) -> locked=1 one cycle after 1110 is sampled; phase=3; err_count=0.
REQ-032 Wrap: while locked, run 0011,0001,0000 -> wrap_pulse high for exactly 1 cycle, after 0000 is sampled; phase=0; locked stays 1.
REQ-033 Illegal code: while locked at 1100, inject 1010 -> err_pulse=1 for 1 cycle, locked=0, phase holds 2, err_count=1. Then 1110,1111,0111,0011 -> relock after 0011.
REQ-034 Skip and stall: while locked at 1000, send 1110 (skip) -> err_pulse=1 and SEARCH. Relock, then send 1111,1111 (repeat) -> err_pulse=1 on the repeat. With jc_valid=0 for 5 cycles, all outputs hold.
REQ-035 Saturation with ERR_W=2: 5 illegal samples -> err_count sequence 1,2,3,3,3 and 5 err_pulses.
REQ-036 Mid-lock reset: assert reset while locked at phase 5 -> next cycle locked=0, phase=0, err_count=0, phase_onehot=01 (macro defined) or 00 (macro undefined).

Source files
------------

// File: rtl/johnson_phase_tracker.sv
`default_nettype none
// ============================================================================
// johnson_phase_tracker : decodes a 4-bit Johnson code, locks onto a clean
// phase sequence and counts sequence errors.
// Optional one-hot phase output is built when JOHNSON_PHASE_ONEHOT_EN is defined.
// Revision: 1.0
// ============================================================================
module johnson_phase_tracker #(
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       jc_in,
  input  logic             jc_valid,
  output logic [2:0]       phase,
  output logic [7:0]       phase_onehot,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

  state_t     state_q, state_d;
  logic [3:0] match_q, match_d;
  logic       prev_valid_q, prev_valid_d;
  logic [2:0] phase_d;
  logic       err_d, wrap_d;
  logic       dec_legal;
  logic [2:0] dec_phase;
  logic       is_succ;

  always_comb begin
    dec_legal = 1'b1;
    dec_phase = 3'd0;
    case (jc_in)
      4'b0000: dec_phase = 3'd0;
      4'b1000: dec_phase = 3'd1;
      4'b1100: dec_phase = 3'd2;
      4'b1110: dec_phase = 3'd3;
      4'b1111: dec_phase = 3'd4;
      4'b0111: dec_phase = 3'd5;
      4'b0011: dec_phase = 3'd6;
      4'b0001: dec_phase = 3'd7;
      default: dec_legal = 1'b0;
    endcase
  end

  // The stored previous sample always equals the phase register when valid,
  // so only its validity needs separate tracking.
  assign is_succ = prev_valid_q && dec_legal && (dec_phase == phase + 3'd1);

  always_comb begin
    state_d      = state_q;
    match_d      = match_q;
    prev_valid_d = prev_valid_q;
    phase_d      = phase;
    err_d        = 1'b0;
    wrap_d       = 1'b0;
    if (jc_valid) begin
      if (!dec_legal) begin
        state_d      = SEARCH;
        match_d      = 4'd0;
        prev_valid_d = 1'b0;
        err_d        = 1'b1;
      end else begin
        phase_d = dec_phase;
        case (state_q)
          SEARCH: begin
            prev_valid_d = 1'b1;
            if (is_succ) begin
              match_d = match_q + 4'd1;
              if (match_d == LOCK_TARGET) begin
                state_d = LOCKED;
              end
            end else begin
              match_d = 4'd0;
            end
          end
          LOCKED: begin
            if (is_succ) begin
              wrap_d = (phase == 3'd7);
            end else begin
              // Invalidate the stored sample so the next legal one is a fresh start.
              state_d      = SEARCH;
              match_d      = 4'd0;
              prev_valid_d = 1'b0;
              err_d        = 1'b1;
            end
          end
          default: state_d = SEARCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SEARCH;
      match_q      <= 4'd0;
      prev_valid_q <= 1'b0;
      phase        <= 3'd0;
      err_pulse    <= 1'b0;
      wrap_pulse   <= 1'b0;
      err_count    <= '0;
    end else begin
      state_q      <= state_d;
      match_q      <= match_d;
      prev_valid_q <= prev_valid_d;
      phase        <= phase_d;
      err_pulse    <= err_d;
      wrap_pulse   <= wrap_d;
      if (err_d && (err_count != {ERR_W{1'b1}})) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

  assign locked = (state_q == LOCKED);

`ifdef JOHNSON_PHASE_ONEHOT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_onehot <= 8'h01;
    end else begin
      phase_onehot <= 8'h01 << phase_d;
    end
  end
`else
  assign phase_onehot = 8'h00;
`endif

endmodule
`default_nettype wire
